// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared digit codes, glyph constants and widths for the scan multiplexer
package display_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [6:0]        seg_t;

    localparam code_t CODE_ZERO  = 5'd0;
    localparam code_t CODE_MINUS = 5'd16;
    localparam code_t CODE_BLANK = 5'd31;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_MINUS = 7'b0111111;

endpackage

// File: rtl/display_scan_mux_if.sv
// rtl/display_scan_mux_if.sv - host load port and display drive pins of the scan multiplexer
interface display_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    import display_pkg::*;

    logic                       load;
    logic [CODE_W*N_DIGITS-1:0] data_in;
    logic [N_DIGITS-1:0]        dp_in;
    logic                       blank_lz_en;

    seg_t                       seg;
    logic                       dp;
    logic [N_DIGITS-1:0]        an;
    logic                       frame_tick;

    modport master (
        output load, data_in, dp_in, blank_lz_en,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  load, data_in, dp_in, blank_lz_en,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 5-bit digit code to active-low seven-segment glyph
module seg7_decode
    import display_pkg::*;
(
    input  code_t code,
    output seg_t  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:       seg = 7'b1000000;
            5'd1:       seg = 7'b1111001;
            5'd2:       seg = 7'b0100100;
            5'd3:       seg = 7'b0110000;
            5'd4:       seg = 7'b0011001;
            5'd5:       seg = 7'b0010010;
            5'd6:       seg = 7'b0000010;
            5'd7:       seg = 7'b1111000;
            5'd8:       seg = 7'b0000000;
            5'd9:       seg = 7'b0010000;
            5'd10:      seg = 7'b0001000;
            5'd11:      seg = 7'b0000011;
            5'd12:      seg = 7'b1000110;
            5'd13:      seg = 7'b0100001;
            5'd14:      seg = 7'b0000110;
            5'd15:      seg = 7'b0001110;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed seven-segment driver with frame-synchronous updates
module display_scan_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input logic               clk,
    input logic               rst,
    display_scan_mux_if.slave bus
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(N_DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_PRE  = SLOT_W'(SCAN_DIV - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [SLOT_W-1:0]          slot_cnt;
    logic [IDX_W-1:0]           digit_idx;
    logic                       slot_wrap;
    logic                       frame_wrap;

    code_t [N_DIGITS-1:0]       stage_code;
    logic  [N_DIGITS-1:0]       stage_dp;
    code_t [N_DIGITS-1:0]       disp_code;
    logic  [N_DIGITS-1:0]       disp_dp;
    logic                       pending;

    logic  [N_DIGITS-1:0]       lz_blank;
    logic                       lz_run;
    code_t                      sel_code;
    seg_t                       sel_seg;

    seg_t                       seg_q;
    logic                       dp_q;
    logic  [N_DIGITS-1:0]       an_q;
    logic                       frame_tick_q;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (digit_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt     <= '0;
            digit_idx    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            // Raised one cycle early so the registered pulse lands on the wrap cycle itself.
            frame_tick_q <= (slot_cnt == SLOT_PRE) && (digit_idx == IDX_LAST);
        end
    end

    // The display register only moves on a frame wrap, so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_code <= {N_DIGITS{CODE_BLANK}};
            stage_dp   <= '0;
            disp_code  <= {N_DIGITS{CODE_BLANK}};
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else if (frame_wrap) begin
            if (bus.load) begin
                disp_code <= bus.data_in;
                disp_dp   <= bus.dp_in;
            end else if (pending) begin
                disp_code <= stage_code;
                disp_dp   <= stage_dp;
            end
            pending <= 1'b0;
        end else if (bus.load) begin
            stage_code <= bus.data_in;
            stage_dp   <= bus.dp_in;
            pending    <= 1'b1;
        end
    end

    // Zeros are blanked from the most significant digit down until any non-zero code; digit 0 is always shown.
    always_comb begin
        lz_run   = bus.blank_lz_en;
        lz_blank = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            lz_run      = lz_run && (disp_code[k] == CODE_ZERO);
            lz_blank[k] = lz_run;
        end
    end

    assign sel_code = lz_blank[digit_idx] ? CODE_BLANK : disp_code[digit_idx];

    seg7_decode u_decode (
        .code (sel_code),
        .seg  (sel_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= sel_seg;
            dp_q  <= ~disp_dp[digit_idx];
            an_q  <= (slot_cnt == '0) ? '1 : ~(N_DIGITS'(1) << digit_idx);
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - scoreboard bench for display_scan_mux against a frame-level reference model
module tb_display_scan_mux;
    import display_pkg::*;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int NS = N * S;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         tick;
    } out_t;

    localparam out_t RST_OUT = {7'b1111111, 1'b1, {N{1'b1}}, 1'b0};

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst;
    int   tb_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    int   tgt_q[$];
    out_t exp_q[$];
    out_t mon_act;
    out_t mon_exp;

    int           m_cyc;
    logic [4:0]   m_latest [N];
    logic [4:0]   m_frame  [N];
    logic [N-1:0] m_latest_dp;
    logic [N-1:0] m_frame_dp;
    bit           cur_blz;

    display_scan_mux_if #(.N_DIGITS(N)) bus ();

    display_scan_mux #(.N_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [3:0] lo;
        lo = c[3:0];
        if (c < 5'd16) return HEX_GLYPH[lo];
        if (c == 5'd16) return 7'b0111111;
        return 7'b1111111;
    endfunction

    // Expected pins one cycle after model cycle s of the current frame.
    function automatic out_t model_out(input int s, input bit blz);
        int   d;
        int   pos;
        bit   blank;
        out_t o;
        d     = (s / S) % N;
        pos   = s % S;
        blank = blz && (d > 0);
        for (int j = d; j < N; j++)
            if (m_frame[j] != 5'd0) blank = 1'b0;
        o.seg  = blank ? 7'b1111111 : glyph(m_frame[d]);
        o.dp   = ~m_frame_dp[d];
        o.an   = '1;
        if (pos != 0) o.an[d] = 1'b0;
        o.tick = (((s + 1) % NS) == NS - 1);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_latest[k] = 5'd31;
            m_frame[k]  = 5'd31;
        end
        m_latest_dp = '0;
        m_frame_dp  = '0;
        m_cyc       = 0;
    endtask

    task automatic cycle_step(input bit r, input bit ld, input logic [5*N-1:0] d, input logic [N-1:0] p);
        out_t e;
        rst             = r;
        bus.load        = ld;
        bus.data_in     = d;
        bus.dp_in       = p;
        bus.blank_lz_en = cur_blz;
        e = r ? RST_OUT : model_out(m_cyc, cur_blz);
        tgt_q.push_back(tb_cyc + 1);
        exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (ld) begin
                for (int k = 0; k < N; k++) m_latest[k] = d[5*k +: 5];
                m_latest_dp = p;
            end
            // Each frame shows the most recent load issued before it started.
            if (m_cyc % NS == NS - 1) begin
                m_frame    = m_latest;
                m_frame_dp = m_latest_dp;
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic run_to_phase(input int ph);
        while (m_cyc % NS != ph) cycle_step(1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [5*N-1:0] rand_data();
        logic [5*N-1:0] v;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0:       v[5*k +: 5] = 5'd0;
                1:       v[5*k +: 5] = 5'd16;
                default: v[5*k +: 5] = 5'($urandom_range(0, 31));
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (tgt_q.size() > 0 && tgt_q[0] == tb_cyc) begin
            mon_exp = exp_q.pop_front();
            void'(tgt_q.pop_front());
            mon_act = {bus.seg, bus.dp, bus.an, bus.frame_tick};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL pins@%0d got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b",
                         tb_cyc, mon_act.seg, mon_act.dp, mon_act.an, mon_act.tick,
                         mon_exp.seg, mon_exp.dp, mon_exp.an, mon_exp.tick);
            end
        end
        if (done) begin
            checks++;
            if (tgt_q.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d unchecked entries want 0", tgt_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.load        = 1'b0;
        bus.data_in     = '0;
        bus.dp_in       = '0;
        bus.blank_lz_en = 1'b0;
        cur_blz         = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle_step(1'b1, 1'b0, '0, '0);
        cycle_step(1'b1, 1'b1, {4{5'd8}}, 4'b1111);

        // Idle blank frames, then a mid-frame load with and without zero blanking.
        idle(40);
        run_to_phase(6);
        cycle_step(1'b0, 1'b1, {5'd0, 5'd0, 5'd1, 5'd9}, 4'b0010);
        idle(40);
        cur_blz = 1'b1;
        idle(20);

        // Last load in a frame wins; minus stops the zero run.
        run_to_phase(3);
        cycle_step(1'b0, 1'b1, {4{5'd8}}, 4'b1111);
        idle(3);
        cycle_step(1'b0, 1'b1, {5'd16, 5'd0, 5'd0, 5'd7}, 4'b0000);
        idle(36);

        // Load on the wrap cycle commits directly and supersedes the staged load.
        run_to_phase(4);
        cycle_step(1'b0, 1'b1, {5'd10, 5'd11, 5'd12, 5'd13}, 4'b0101);
        run_to_phase(15);
        cycle_step(1'b0, 1'b1, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b1000);
        idle(36);

        // Reset mid-slot discards a pending load.
        run_to_phase(5);
        cycle_step(1'b0, 1'b1, {5'd2, 5'd4, 5'd6, 5'd8}, 4'b1111);
        idle(3);
        cycle_step(1'b1, 1'b0, '0, '0);
        cycle_step(1'b1, 1'b0, '0, '0);
        idle(40);

        for (int i = 0; i < 600; i++) begin
            if (i % 24 == 0) cur_blz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0)
                cycle_step(1'b1, 1'b0, '0, '0);
            else
                cycle_step(1'b0, ($urandom_range(0, 5) == 0), rand_data(), N'($urandom_range(0, 15)));
        end
        idle(4);
        @(posedge clk);
        done = 1'b1;
    end

endmodule
